pwm_meter: RTL

Measures the waveform produced by the PWM generator stage, directly downstream of it on the same `cclk` domain. On every rising edge of `pwm` it reports the length of the period just completed and the number of high cycles in it, both in `cclk` cycles, with a one-cycle `valid` strobe. It flags a stalled waveform (no rising edge within the counter range). Its outputs feed self-check logic and the debug readout.

---
 rtl/pwm_meter.sv | 61 ++++++
 1 files changed

// File: rtl/pwm_meter.sv
// pwm_meter: measures period and high time of a cclk-synchronous PWM waveform, flags a stalled input
module pwm_meter #(
    parameter int WIDTH = 16
) (
    input  logic             cclk,
    input  logic             rstb,
    input  logic             pwm,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic [7:0]       meas_count
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t           state;
    logic             pwm_d;
    logic [WIDTH-1:0] period_cnt;
    logic [WIDTH-1:0] high_cnt;
    logic             rise;
    logic             at_max;
    assign rise   = pwm & ~pwm_d;
    assign at_max = &period_cnt;
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state      <= IDLE;
            pwm_d      <= 1'b1;
            period_cnt <= '0;
            high_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            meas_count <= '0;
        end else begin
            pwm_d <= pwm;
            valid <= 1'b0;
            if (rise) begin
                period_cnt <= WIDTH'(1);
                high_cnt   <= WIDTH'(1);
                state      <= MEASURE;
                stuck      <= 1'b0;
                if (state == MEASURE) begin
                    period     <= period_cnt;
                    high_time  <= high_cnt;
                    valid      <= 1'b1;
                    meas_count <= meas_count + 8'd1;
                end
            end else if (state == MEASURE) begin
                if (at_max) begin
                    stuck      <= 1'b1;
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    state      <= IDLE;
                end else begin
                    period_cnt <= period_cnt + WIDTH'(1);
                    high_cnt   <= high_cnt + WIDTH'(pwm);
                end
            end
        end
    end
endmodule
